// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle slave for the MEM-stage memread/memwrite interface.
// Accepts one word load/store at a time and holds the pipeline (stall) for LATENCY
// cycles. It then performs the access against an internal word-addressed RAM and
// returns registered read_data together with a one-cycle ready pulse. An err pulse
// accompanies ready when the address is misaligned or beyond the RAM.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,  // power of two
  parameter int unsigned LATENCY     = 2     // >= 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic        memread,
  input  logic        memwrite,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        stall,
  output logic        err
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_START = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic              is_store_q;
  logic [31:0]       read_data_q;
  logic              ready_q;
  logic              err_q;
  logic [31:0]       ram_q [DEPTH_WORDS];

  // Decode of the captured request; only meaningful while BUSY.
  logic [IDX_W-1:0]  word_idx;
  logic              in_range;
  logic              misaligned;
  logic              access_now;
  logic              ram_we;
  logic [31:0]       read_data_d;

  assign word_idx    = addr_q[IDX_W+1:2];
  assign in_range    = (addr_q[31:IDX_W+2] == '0);
  assign misaligned  = (addr_q[1:0] != 2'b00);
  assign access_now  = (state_q == S_BUSY) && (cnt_q == '0);
  // Out-of-range stores are dropped so they cannot alias onto a real word.
  assign ram_we      = access_now && is_store_q && in_range;
  // Out-of-range loads return zero instead of an aliased word.
  assign read_data_d = in_range ? ram_q[word_idx] : 32'h0;

  // Hold the pipeline while a request is being presented or is in flight.
  // It is released in DONE so that the MEM stage advances in the ready cycle.
  assign stall = ((state_q == S_IDLE) && (memread || memwrite)) || (state_q == S_BUSY);

  assign read_data = read_data_q;
  assign ready     = ready_q;
  assign err       = err_q;

  // Request FSM: capture in IDLE, count down in BUSY, pulse ready/err in DONE.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so that every register
    // samples pre-edge values, independent of statement order.
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      is_store_q  <= 1'b0;
      read_data_q <= '0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (memread || memwrite) begin
            addr_q     <= addr;
            wdata_q    <= write_data;
            is_store_q <= memwrite;  // read+write together is a store
            cnt_q      <= CNT_START;
            state_q    <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            if (!is_store_q) begin
              read_data_q <= read_data_d;
            end
            ready_q <= 1'b1;
            err_q   <= misaligned || !in_range;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Word RAM: written at the access edge of an in-range store.
  always_ff @(posedge clk) begin
    // NOTE: the RAM is deliberately cleared on reset, so it maps to flops rather
    // than a RAM macro; a reset-free array would be needed to infer block RAM.
    if (rst) begin
      ram_q <= '{default: 32'h0};
    end else if (ram_we) begin
      ram_q[word_idx] <= wdata_q;
    end
  end

endmodule
